seq_mac_alu: RTL

Parametrised, multi-cycle successor to the combinational signed ALU: computes OUT = A + B*C (or OUT = OUT_prev + A + B*C in accumulate mode) with a serial shift-add multiplier. Operand width is a parameter, and C can be treated as unsigned or signed per operation. Sits between an operand producer and a result consumer with valid/ready handshakes on both sides. It reports two's-complement overflow on the result.

---
 rtl/seq_mac_alu.sv | 133 +++++++++++++
 1 files changed

// File: rtl/seq_mac_alu.sv
// Sequential multiply-accumulate ALU: OUT = A + B*C, or OUT_prev + A + B*C when ACC is set.
// C is consumed one bit per cycle by a shift-add multiplier; valid/ready on both sides.
module seq_mac_alu #(
   parameter int W = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [W-1:0]     a_i,
   input  logic [W-1:0]     b_i,
   input  logic [W-1:0]     c_i,
   input  logic             c_sgn_i,
   input  logic             acc_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [2*W-1:0]   out_o,
   output logic             ovf_o
);

   // Two guard bits above the result width catch any accumulate wrap.
   localparam int SW = 2*W + 2;
   localparam int CW = (W > 2) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST = CW'(W-1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MUL  = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   logic [1:0]    state_q,    state_d;
   logic [SW-1:0] sum_q,      sum_d;
   logic [SW-1:0] mulB_q,     mulB_d;
   logic [W-1:0]  mulC_q,     mulC_d;
   logic          cSgn_q,     cSgn_d;
   logic [CW-1:0] bitCnt_q,   bitCnt_d;
   logic [2*W-1:0] out_q,     out_d;
   logic          ovf_q,      ovf_d;
   logic          outValid_q, outValid_d;

   logic [SW-1:0] partial;
   logic [SW-1:0] sumStep;
   logic [2:0]    topBits;

   assign in_ready_o  = (state_q == IDLE) & ~rst_i;
   assign out_valid_o = outValid_q;
   assign out_o       = out_q;
   assign ovf_o       = ovf_q;

   always_comb begin
      state_d    = state_q;
      sum_d      = sum_q;
      mulB_d     = mulB_q;
      mulC_d     = mulC_q;
      cSgn_d     = cSgn_q;
      bitCnt_d   = bitCnt_q;
      out_d      = out_q;
      ovf_d      = ovf_q;
      outValid_d = outValid_q;

      // mulB_q already holds sext(B)<<k; the signed MSB of C carries negative weight.
      partial = mulB_q;
      if (cSgn_q && (bitCnt_q == LAST)) begin
         partial = -mulB_q;
      end
      sumStep = mulC_q[0] ? (sum_q + partial) : sum_q;
      topBits = sumStep[2*W+1:2*W-1];

      case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               mulB_d   = {{(SW-W){b_i[W-1]}}, b_i};
               mulC_d   = c_i;
               cSgn_d   = c_sgn_i;
               bitCnt_d = '0;
               if (acc_i) begin
                  sum_d = {{2{out_q[2*W-1]}}, out_q} + {{(SW-W){a_i[W-1]}}, a_i};
               end else begin
                  sum_d = {{(SW-W){a_i[W-1]}}, a_i};
               end
               state_d = MUL;
            end
         end
         MUL: begin
            sum_d    = sumStep;
            mulB_d   = mulB_q << 1;
            mulC_d   = mulC_q >> 1;
            bitCnt_d = bitCnt_q + CW'(1);
            if (bitCnt_q == LAST) begin
               out_d      = sumStep[2*W-1:0];
               ovf_d      = ~((topBits == 3'b000) || (topBits == 3'b111));
               outValid_d = 1'b1;
               bitCnt_d   = '0;
               state_d    = HOLD;
            end
         end
         HOLD: begin
            if (out_ready_i) begin
               outValid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Reset wins over everything, discarding any operation still in the multiplier.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         sum_q      <= '0;
         mulB_q     <= '0;
         mulC_q     <= '0;
         cSgn_q     <= 1'b0;
         bitCnt_q   <= '0;
         out_q      <= '0;
         ovf_q      <= 1'b0;
         outValid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sum_q      <= sum_d;
         mulB_q     <= mulB_d;
         mulC_q     <= mulC_d;
         cSgn_q     <= cSgn_d;
         bitCnt_q   <= bitCnt_d;
         out_q      <= out_d;
         ovf_q      <= ovf_d;
         outValid_q <= outValid_d;
      end
   end

endmodule
